// File: rtl/agex_div_sequencer_pkg.sv
// Shared types for the AGEX divide unit: op encodings, FSM states and the
// mapping from AGEX divide-class opcodes onto div_op.
package agex_div_sequencer_pkg;

   typedef enum logic [1:0] {
      DIVOP_DIV  = 2'b00,
      DIVOP_DIVU = 2'b01,
      DIVOP_REM  = 2'b10,
      DIVOP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      DIVS_IDLE = 2'b00,
      DIVS_BUSY = 2'b01,
      DIVS_DONE = 2'b10
   } div_state_e;

   // Divide-class instruction identifiers as decoded by AGEX
   typedef enum logic [1:0] {
      DIV_I  = 2'b00,
      DIVU_I = 2'b01,
      REM_I  = 2'b10,
      REMU_I = 2'b11
   } agex_div_inst_e;

   function automatic div_op_e agex_to_div_op(input agex_div_inst_e inst);
      div_op_e op;
      case (inst)
         DIV_I:   op = DIVOP_DIV;
         DIVU_I:  op = DIVOP_DIVU;
         REM_I:   op = DIVOP_REM;
         default: op = DIVOP_REMU;
      endcase
      return op;
   endfunction

   function automatic logic is_signed_op(input div_op_e op);
      return ~op[0];
   endfunction

   function automatic logic is_rem_op(input div_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/agex_div_sequencer_if.sv
// AGEX <-> divide unit handshake: operands in, stall/result back.
interface agex_div_sequencer_if
   import agex_div_sequencer_pkg::*;
#(
   parameter int DBITS = 32
);
   logic             start;
   div_op_e          div_op;
   logic [DBITS-1:0] src_a;
   logic [DBITS-1:0] src_b;
   logic             flush;
   logic             stall_div;
   logic             busy;
   logic             result_valid;
   logic [DBITS-1:0] result;

   modport master (
      output start, div_op, src_a, src_b, flush,
      input  stall_div, busy, result_valid, result
   );

   modport slave (
      input  start, div_op, src_a, src_b, flush,
      output stall_div, busy, result_valid, result
   );
endinterface

// File: rtl/agex_div_sequencer_step.sv
// One restoring-divide iteration: shift in the next dividend bit, subtract
// the divisor when it fits and record the quotient bit.
module agex_div_sequencer_step #(
   parameter int DBITS = 32
) (
   input  logic [DBITS:0]   i_rem,
   input  logic [DBITS-1:0] i_quo,
   input  logic [DBITS-1:0] i_divisor,
   output logic [DBITS:0]   o_rem,
   output logic [DBITS-1:0] o_quo
);
   // rem top bit is always 0 between iterations, so the wide shift is exact
   logic [DBITS+1:0] w_sh;
   logic             w_ge;

   assign w_sh = {i_rem, i_quo[DBITS-1]};
   assign w_ge = (w_sh >= {2'b00, i_divisor});

   always_comb begin
      o_rem = (DBITS+1)'(w_sh);
      o_quo = {i_quo[DBITS-2:0], 1'b0};
      if (w_ge) begin
         o_rem = (DBITS+1)'(w_sh - {2'b00, i_divisor});
         o_quo = {i_quo[DBITS-2:0], 1'b1};
      end
   end
endmodule

// File: rtl/agex_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: one quotient bit per cycle, stalls the
// front end while busy and presents the result for a single cycle.
module agex_div_sequencer
   import agex_div_sequencer_pkg::*;
#(
   parameter int DBITS   = 32,
   parameter int CNTBITS = 5
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   agex_div_sequencer_if.slave   io
);
   localparam logic [CNTBITS-1:0] LAST_CNT = CNTBITS'(DBITS-1);
   localparam logic [DBITS-1:0]   MIN_NEG  = {1'b1, {(DBITS-1){1'b0}}};

   div_state_e         r_state, w_state_n;
   div_op_e            r_op;
   logic [DBITS:0]     r_rem;
   logic [DBITS-1:0]   r_quo, r_div, r_result;
   logic [CNTBITS-1:0] r_cnt;
   logic               r_neg_q, r_neg_r, r_result_valid, r_busy;

   logic               w_in_signed, w_b_zero, w_ovf, w_special, w_stall;
   logic [DBITS-1:0]   w_abs_a, w_abs_b, w_special_res;
   logic [DBITS:0]     w_rem_n;
   logic [DBITS-1:0]   w_quo_n, w_fix_q, w_fix_r, w_final;

   assign w_in_signed = is_signed_op(io.div_op);
   assign w_b_zero    = (io.src_b == '0);
   assign w_ovf       = w_in_signed && (io.src_a == MIN_NEG) && (io.src_b == '1);
   assign w_special   = w_b_zero || w_ovf;
   assign w_abs_a     = (w_in_signed && io.src_a[DBITS-1]) ? -io.src_a : io.src_a;
   assign w_abs_b     = (w_in_signed && io.src_b[DBITS-1]) ? -io.src_b : io.src_b;

   always_comb begin
      w_special_res = '0;
      if (w_b_zero)
         w_special_res = is_rem_op(io.div_op) ? io.src_a : '1;
      else if (!is_rem_op(io.div_op))
         w_special_res = MIN_NEG;
   end

   agex_div_sequencer_step #(.DBITS(DBITS)) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_div),
      .o_rem     (w_rem_n),
      .o_quo     (w_quo_n)
   );

   // Fix-up works on the last step's output so the result registers at DONE entry
   assign w_fix_q = r_neg_q ? -w_quo_n : w_quo_n;
   assign w_fix_r = r_neg_r ? -w_rem_n[DBITS-1:0] : w_rem_n[DBITS-1:0];
   assign w_final = is_rem_op(r_op) ? w_fix_r : w_fix_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= DIVS_IDLE;
      else         r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      w_stall   = 1'b0;
      case (r_state)
         DIVS_IDLE: begin
            if (io.start && !io.flush) begin
               w_stall   = 1'b1;
               w_state_n = w_special ? DIVS_DONE : DIVS_BUSY;
            end
         end
         DIVS_BUSY: begin
            w_stall = !io.flush;
            if (r_cnt == LAST_CNT) w_state_n = DIVS_DONE;
         end
         DIVS_DONE: w_state_n = DIVS_IDLE;
         default:   w_state_n = DIVS_IDLE;
      endcase
      if (io.flush) w_state_n = DIVS_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_op           <= DIVOP_DIV;
         r_rem          <= '0;
         r_quo          <= '0;
         r_div          <= '0;
         r_cnt          <= '0;
         r_neg_q        <= 1'b0;
         r_neg_r        <= 1'b0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         r_busy         <= (w_state_n != DIVS_IDLE);
         case (r_state)
            DIVS_IDLE: begin
               if (io.start && !io.flush) begin
                  r_op <= io.div_op;
                  if (w_special) begin
                     r_result       <= w_special_res;
                     r_result_valid <= 1'b1;
                  end else begin
                     r_rem   <= '0;
                     r_quo   <= w_abs_a;
                     r_div   <= w_abs_b;
                     r_cnt   <= '0;
                     r_neg_q <= w_in_signed && (io.src_a[DBITS-1] ^ io.src_b[DBITS-1]);
                     r_neg_r <= w_in_signed && io.src_a[DBITS-1];
                  end
               end
            end
            DIVS_BUSY: begin
               r_rem <= w_rem_n;
               r_quo <= w_quo_n;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT && !io.flush) begin
                  r_result       <= w_final;
                  r_result_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign io.stall_div    = w_stall;
   assign io.busy         = r_busy;
   assign io.result_valid = r_result_valid && !io.flush;
   assign io.result       = r_result;
endmodule

// File: tb/tb_agex_div_sequencer.sv
// Directed checks of the divide sequencer: operand table plus flush, reset
// and back-to-back timing sequences.
module tb_agex_div_sequencer;
   import agex_div_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   agex_div_sequencer_if #(.DBITS(32)) bus ();

   agex_div_sequencer #(.DBITS(32), .CNTBITS(5)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .io      (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.div_op = DIVOP_DIV;
      bus.src_a  = '0;
      bus.src_b  = '0;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.div_op = div_op_e'(op);
      bus.src_a  = a;
      bus.src_b  = b;
   endtask

   // Issue one op at cycle 0 and watch 40 cycles for latency, value, stalls.
   task automatic run_vec(input int idx, input vec_t v);
      int first_c, pulses, stalls;
      logic [31:0] res;
      string tag;
      first_c = -1; pulses = 0; stalls = 0; res = '0;
      tag = $sformatf("vec%0d", idx);
      @(posedge clk); #1;
      bus.start = 1'b1;
      set_op(v.op, v.a, v.b);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.stall_div) stalls++;
         if (bus.result_valid) begin
            pulses++;
            if (first_c < 0) begin first_c = c; res = bus.result; end
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      chk({tag, "_result"}, res, v.exp);
      chk({tag, "_latency"}, 32'(first_c), 32'(v.lat));
      chk({tag, "_stalls"}, 32'(stalls), 32'(v.lat));
      chk({tag, "_pulses"}, 32'(pulses), 32'd1);
   endtask

   initial begin
      int pulses, first_c, second_c;
      logic [31:0] r1, r2;

      vecs[0]  = '{2'b01, 32'd100,       32'd7,         32'd14,        33};
      vecs[1]  = '{2'b11, 32'd100,       32'd7,         32'd2,         33};
      vecs[2]  = '{2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
      vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[4]  = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[5]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
      vecs[6]  = '{2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[7]  = '{2'b10, 32'd5,         32'd0,         32'd5,         1};
      vecs[8]  = '{2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{2'b11, 32'd5,         32'd0,         32'd5,         1};
      vecs[10] = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      vecs[12] = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
      vecs[13] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[14] = '{2'b00, 32'h8000_0000, 32'd2,         32'hC000_0000, 33};
      vecs[15] = '{2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
      vecs[16] = '{2'b10, 32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFE, 33};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.result_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_stall", 32'(bus.stall_div), 32'd0);

      for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

      // Flush mid-divide, then a fresh divide two cycles later
      pulses = 0; first_c = -1; r1 = '0;
      @(posedge clk); #1;
      for (int c = 0; c <= 50; c++) begin
         bus.start = (c == 0) || (c == 12);
         bus.flush = (c == 10);
         if (c == 0)  set_op(2'b01, 32'hFFFF_FFFF, 32'd1);
         if (c == 12) set_op(2'b01, 32'd9, 32'd3);
         @(negedge clk);
         if (c == 10) chk("flush_stall_drop", 32'(bus.stall_div), 32'd0);
         if (c == 11) chk("flush_idle", 32'(bus.busy), 32'd0);
         if (bus.result_valid) begin
            pulses++;
            if (first_c < 0) begin first_c = c; r1 = bus.result; end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      chk("flush_pulses", 32'(pulses), 32'd1);
      chk("flush_new_cycle", 32'(first_c), 32'd45);
      chk("flush_new_result", r1, 32'd3);

      // start held through DONE, second op accepted in the IDLE cycle after
      pulses = 0; first_c = -1; second_c = -1; r1 = '0; r2 = '0;
      @(posedge clk); #1;
      for (int c = 0; c <= 72; c++) begin
         bus.start = (c <= 34);
         if (c < 34) set_op(2'b01, 32'd100, 32'd7);
         else        set_op(2'b01, 32'd50, 32'd5);
         @(negedge clk);
         if (bus.result_valid) begin
            pulses++;
            if (first_c < 0) begin first_c = c; r1 = bus.result; end
            else if (second_c < 0) begin second_c = c; r2 = bus.result; end
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      chk("b2b_pulses", 32'(pulses), 32'd2);
      chk("b2b_first_cycle", 32'(first_c), 32'd33);
      chk("b2b_first_result", r1, 32'd14);
      chk("b2b_second_cycle", 32'(second_c), 32'd67);
      chk("b2b_second_result", r2, 32'd10);

      // Reset in cycle 5 of a running divide
      pulses = 0;
      @(posedge clk); #1;
      for (int c = 0; c <= 40; c++) begin
         bus.start = (c == 0);
         if (c == 0) set_op(2'b01, 32'd100, 32'd7);
         reset = (c == 5);
         @(negedge clk);
         if (c == 6) begin
            chk("midrst_busy", 32'(bus.busy), 32'd0);
            chk("midrst_valid", 32'(bus.result_valid), 32'd0);
            chk("midrst_result", bus.result, 32'd0);
            chk("midrst_stall", 32'(bus.stall_div), 32'd0);
         end
         if (bus.result_valid) pulses++;
         @(posedge clk); #1;
      end
      reset = 1'b0;
      chk("midrst_pulses", 32'(pulses), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/agex_div_sequencer.md
# agex_div_sequencer

Multi-cycle integer divide/remainder unit and its sequencing controller, attached to AGEX. It accepts RV32M DIV/DIVU/REM/REMU operands from the AGEX operand path and runs a restoring divide at one quotient bit per cycle. While the divide runs it holds the front of the pipeline with a stall. It presents the result for exactly one cycle so the AGEX latch captures it.

## Interface
- `DBITS`, 32: operand and result width.
- `CNTBITS`, 5: iteration counter width; must equal clog2(`DBITS`).
- `clk`  in  1  pipeline clock.
- `reset`  in  1  reset, synchronous, active-high; one clock, no other clock domains.
- `start`  in  1  AGEX holds a valid divide-class instruction this cycle.
- `div_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `src_a`  in  `DBITS`  dividend (rs1 value).
- `src_b`  in  `DBITS`  divisor (rs2 value).
- `flush`  in  1  squash the in-flight divide (branch mispredict / redirect from AGEX).
- `stall_div`  out  1  hold FE, DE and the AGEX input latch this cycle.
- `busy`  out  1  FSM not IDLE.
- `result_valid`  out  1  `result` valid this cycle.
- `result`  out  `DBITS`  quotient or remainder per latched `div_op`.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset and `flush` both force IDLE on the next edge.
- IDLE:
  - `start`=1 and `flush`=0: latch `div_op`.
  - If `src_b`==0 or signed overflow (`div_op`=DIV/REM, `src_a`=0x8000_0000, `src_b`=0xFFFF_FFFF): load the special result and go to DONE.
  - Otherwise: load |a| and |b| (absolute values for DIV/REM, raw values for DIVU/REMU), clear the remainder and counter, and go to BUSY.
- BUSY, per cycle:
  - rem' = {rem[DBITS-1:0], quo[DBITS-1]}; quo shifts left.
  - If rem' ≥ {0,divisor}: rem = rem' − divisor and the new quotient LSB = 1; else rem = rem' and the LSB = 0.
  - Remainder register is `DBITS`+1 bits.
  - Counter increments. On the iteration where the counter = `DBITS`−1, go to DONE.
- DONE:
  - Result fix-up: for signed ops the quotient is negated if sign(a)≠sign(b), and the remainder takes the sign of a.
  - `result_valid`=1 for exactly one cycle, then IDLE unconditionally.
  - `start` is ignored in DONE and BUSY, so the same instruction is never re-issued.
- Special results:
  - Divide by zero: DIV/DIVU → 0xFFFF_FFFF; REM/REMU → `src_a`.
  - Overflow: DIV → 0x8000_0000; REM → 0.
- `stall_div` = (IDLE & `start` & ~`flush`) | BUSY. It is combinational, and it is low in DONE so the pipeline advances while the result is captured.
- `flush` overrides `start` in every state and suppresses `result_valid` in the same cycle.
- `reset` overrides `flush`.
- Reset values: state IDLE; `stall_div`=0 while `start`=0; `busy`=0; `result_valid`=0; `result`=0. Internal registers are cleared.

## Timing
- Normal divide: `start` is sampled in cycle 0. BUSY covers cycles 1..32. DONE is cycle 33, with `result_valid` high and `stall_div` low. That is 33-cycle latency and 33 stall cycles.
- Special case: `start` in cycle 0, DONE in cycle 1, so 1 stall cycle.
- Back-to-back divides: the next `start` may be accepted in the IDLE cycle following DONE (cycle 34), giving a minimum issue spacing of 34 cycles.
- `result`, `result_valid` and `busy` are registered outputs. `stall_div` is combinational from `start`, `flush` and state.
- `flush` or `reset` mid-BUSY: IDLE on the next edge, `stall_div` drops in the `flush` cycle, and no `result_valid` ever appears for the squashed op.

## Structure
- `define.vh` gains:
  - `DIVOP_DIV`, `DIVOP_DIVU`, `DIVOP_REM`, `DIVOP_REMU`;
  - state encodings `DIVS_IDLE`, `DIVS_BUSY`, `DIVS_DONE`;
  - the AGEX mapping from `DIV_I`/`DIVU_I`/`REM_I`/`REMU_I` to `div_op`.
- One sub-module, `div_restore_step`: a combinational single iteration taking rem, quo and divisor, and returning rem' and quo'. The FSM, counter and sign fix-up stay in `agex_div_sequencer`.
- AGEX ORs `stall_div` into the stall signals in `from_AGEX_to_DE` and `from_AGEX_to_FE`, and selects `result` over the ALU output when `result_valid`.

## Test plan
- DIVU 100/7 → `stall_div` high for cycles 0..32; cycle 33 `result_valid`=1, `result`=14. REMU same operands → 2.
- DIV −7/2 → 0xFFFF_FFFD (−3); REM −7/2 → 0xFFFF_FFFF (−1); DIV 7/−2 → −3.
- DIV 5/0 → 0xFFFF_FFFF at cycle 1; REM 5/0 → 5 at cycle 1; DIV 0x8000_0000/−1 → 0x8000_0000 at cycle 1; REM of the same → 0.
- `start` DIVU 0xFFFF_FFFF/1, `flush` in cycle 10 → IDLE in cycle 11, no `result_valid` through cycle 40; a new DIVU 9/3 started in cycle 12 → 3 at cycle 45.
- `start` held high through DONE → exactly one `result_valid` pulse. A second divide at cycle 34 → result at cycle 67.
- `reset` asserted in cycle 5 of a BUSY op → all outputs at reset values in cycle 6.
